mem_copy_dma: RTL and testbench

//   Memory-side initiator that drives one port of the 16-bit dual-port block RAM.

---
 rtl/mem_dma_pkg.sv | 15 +
 rtl/mem_copy_dma.sv | 165 ++++++++++++++++
 tb/tb_mem_copy_dma.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory-copy DMA and its CPU-side control block.
// Holds the FSM state encoding and the word/address width constants.
package mem_dma_pkg;

    localparam int DMA_DATA_W = 16;
    localparam int DMA_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Memory-side copy engine driving one port of the dual-port block RAM.
// Copies len words from src to dst in ascending order, two cycles per word.
// Optional build macro MEM_COPY_DMA_FILL_EN adds a one-cycle-per-word fill mode
// that writes a constant word instead of copying.
module mem_copy_dma
    import mem_dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
`ifdef MEM_COPY_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    dma_state_t        state;
    dma_state_t        next_state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] index_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wr_data;
    logic              fill_mode;
    logic              accept;
    logic              last_word;

`ifdef MEM_COPY_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_data_q;

    // Fill settings are latched with the rest of the transfer parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q      <= 1'b0;
            fill_data_q <= '0;
        end else if (accept) begin
            fill_q      <= fill;
            fill_data_q <= fill_data;
        end
    end

    assign fill_mode = (state == IDLE) ? fill : fill_q;
    assign wr_data   = fill_q ? fill_data_q : mem_rdata;
`else
    assign fill_mode = 1'b0;
    assign wr_data   = mem_rdata;
`endif

    // abort overrides start so a cancelled request never launches a transfer.
    assign accept    = (state == IDLE) && start && !abort;
    assign last_word = ((index_q + ADDR_W'(1)) == len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; an aborted WR still commits its write on this edge.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (len == '0) begin
                        next_state = DONE;
                    end else if (fill_mode) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                next_state = abort ? IDLE : WR;
            end
            WR: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_word) begin
                    next_state = DONE;
                end else if (fill_mode) begin
                    next_state = WR;
                end else begin
                    next_state = RD;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: capture on start, advance index/count after each write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            index_q <= '0;
            count   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            src_q   <= src;
            dst_q   <= dst;
            len_q   <= len;
            index_q <= '0;
            count   <= '0;
        end else if (state == WR) begin
            index_q <= index_q + ADDR_W'(1);
            count   <= count + ADDR_W'(1);
            wdata_q <= wr_data;
        end
    end

    // Moore output decode; write data passes the RAM read through during WR and holds afterwards.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            RD: begin
                mem_addr = src_q + index_q;
                busy     = 1'b1;
            end
            WR: begin
                mem_addr  = dst_q + index_q;
                mem_wdata = wr_data;
                mem_we    = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed self-checking bench for mem_copy_dma with a behavioural 64K x 16 RAM.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
`ifdef MEM_COPY_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [15:0] fill_data = '0;
`endif
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] count;

    logic [15:0] ram [0:65535];
    logic        ram_init = 1'b0;
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [15:0] tb_wdata = '0;

    int testCount = 0;
    int failCount = 0;
    int busyCycles, doneCycle, doneCount, weCount, nRd, nWr;
    logic [15:0] rdAddr [0:15];
    logic [15:0] wrAddr [0:15];

    mem_copy_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .src       (src),
        .dst       (dst),
        .len       (len),
`ifdef MEM_COPY_DMA_FILL_EN
        .fill      (fill),
        .fill_data (fill_data),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read, write-enable from the DUT or from the bench preload port.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 16'hDEAD;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_wdata;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic writeWord(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_addr = a;
        tb_wdata = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        @(negedge clk);
        src = s;
        dst = d;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic monitor(input int cycles);
        busyCycles = 0; doneCycle = 0; doneCount = 0; weCount = 0; nRd = 0; nWr = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (busy) busyCycles++;
            if (mem_we) begin
                weCount++;
                if (nWr < 16) begin wrAddr[nWr] = mem_addr; nWr++; end
            end else if (busy) begin
                if (nRd < 16) begin rdAddr[nRd] = mem_addr; nRd++; end
            end
            if (done) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = c;
            end
        end
    endtask

    initial begin
        // Reset state and RAM background pattern
        ram_init = 1'b1;
        @(posedge clk);
        #1 ram_init = 1'b0;
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: basic copy of 4 words
        writeWord(16'h0010, 16'h00A1);
        writeWord(16'h0011, 16'h00B2);
        writeWord(16'h0012, 16'h00C3);
        writeWord(16'h0013, 16'h00D4);
        applyStimulus(16'h0010, 16'h0100, 16'd4);
        monitor(12);
        checkOutput("t1_busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("t1_done_cycle", 32'(doneCycle), 32'd9);
        checkOutput("t1_done_count", 32'(doneCount), 32'd1);
        checkOutput("t1_count", 32'(count), 32'd4);
        checkOutput("t1_ram0", 32'(ram[16'h0100]), 32'h00A1);
        checkOutput("t1_ram1", 32'(ram[16'h0101]), 32'h00B2);
        checkOutput("t1_ram2", 32'(ram[16'h0102]), 32'h00C3);
        checkOutput("t1_ram3", 32'(ram[16'h0103]), 32'h00D4);
        checkOutput("t1_ram4_untouched", 32'(ram[16'h0104]), 32'hDEAD);
        checkOutput("t1_wdata_hold", 32'(mem_wdata), 32'h00D4);

        // Test 2: zero-length transfer
        applyStimulus(16'h0010, 16'h0200, 16'd0);
        monitor(4);
        checkOutput("t2_done_cycle", 32'(doneCycle), 32'd1);
        checkOutput("t2_we_count", 32'(weCount), 32'd0);
        checkOutput("t2_busy_cycles", 32'(busyCycles), 32'd0);
        checkOutput("t2_count", 32'(count), 32'd0);
        checkOutput("t2_ram_untouched", 32'(ram[16'h0200]), 32'hDEAD);

        // Test 3: source address wraps past 0xFFFF
        writeWord(16'hFFFE, 16'h1111);
        writeWord(16'hFFFF, 16'h2222);
        writeWord(16'h0000, 16'h3333);
        applyStimulus(16'hFFFE, 16'h2000, 16'd3);
        monitor(10);
        checkOutput("t3_done_cycle", 32'(doneCycle), 32'd7);
        checkOutput("t3_rd_addr0", 32'(rdAddr[0]), 32'hFFFE);
        checkOutput("t3_rd_addr1", 32'(rdAddr[1]), 32'hFFFF);
        checkOutput("t3_rd_addr2", 32'(rdAddr[2]), 32'h0000);
        checkOutput("t3_wr_addr0", 32'(wrAddr[0]), 32'h2000);
        checkOutput("t3_wr_addr2", 32'(wrAddr[2]), 32'h2002);
        checkOutput("t3_ram0", 32'(ram[16'h2000]), 32'h1111);
        checkOutput("t3_ram1", 32'(ram[16'h2001]), 32'h2222);
        checkOutput("t3_ram2", 32'(ram[16'h2002]), 32'h3333);

        // Test 4: abort during the second WR of an 8-word copy
        applyStimulus(16'h0010, 16'h0500, 16'd8);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        checkOutput("t4_in_wr1_we", 32'(mem_we), 32'h1);
        checkOutput("t4_in_wr1_addr", 32'(mem_addr), 32'h0501);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        monitor(6);
        checkOutput("t4_no_done", 32'(doneCount), 32'd0);
        checkOutput("t4_idle_busy", 32'(busyCycles), 32'd0);
        checkOutput("t4_no_writes", 32'(weCount), 32'd0);
        checkOutput("t4_count", 32'(count), 32'd2);
        checkOutput("t4_ram0", 32'(ram[16'h0500]), 32'h00A1);
        checkOutput("t4_ram1", 32'(ram[16'h0501]), 32'h00B2);
        checkOutput("t4_ram2_untouched", 32'(ram[16'h0502]), 32'hDEAD);
        checkOutput("t4_ram7_untouched", 32'(ram[16'h0507]), 32'hDEAD);

        // Test 5: start pulsed while busy is ignored
        applyStimulus(16'h0010, 16'h0600, 16'd4);
        doneCount = 0; busyCycles = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 3) begin start = 1'b1; src = 16'h0020; len = 16'd8; end
            if (c == 4) start = 1'b0;
            if (busy) busyCycles++;
            if (done) doneCount++;
        end
        checkOutput("t5_done_count", 32'(doneCount), 32'd1);
        checkOutput("t5_busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("t5_count", 32'(count), 32'd4);
        checkOutput("t5_ram3", 32'(ram[16'h0603]), 32'h00D4);
        checkOutput("t5_ram4_untouched", 32'(ram[16'h0604]), 32'hDEAD);

        // Test 6: async reset during RD of the third word
        applyStimulus(16'h0010, 16'h0700, 16'd4);
        for (int c = 1; c <= 5; c++) @(negedge clk);
        checkOutput("t6_rd2_busy", 32'(busy), 32'h1);
        checkOutput("t6_rd2_addr", 32'(mem_addr), 32'h0012);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_we", 32'(mem_we), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_done", 32'(done), 32'h0);
        checkOutput("t6_rst_count", 32'(count), 32'h0);
        checkOutput("t6_rst_addr", 32'(mem_addr), 32'h0);
        checkOutput("t6_rst_wdata", 32'(mem_wdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        monitor(4);
        checkOutput("t6_idle_after", 32'(busyCycles + weCount + doneCount), 32'd0);
        checkOutput("t6_ram0", 32'(ram[16'h0700]), 32'h00A1);
        checkOutput("t6_ram1", 32'(ram[16'h0701]), 32'h00B2);
        checkOutput("t6_ram2_untouched", 32'(ram[16'h0702]), 32'hDEAD);
        checkOutput("t6_ram3_untouched", 32'(ram[16'h0703]), 32'hDEAD);

`ifdef MEM_COPY_DMA_FILL_EN
        // Fill mode: constant word, one cycle per word
        @(negedge clk);
        fill = 1'b1;
        fill_data = 16'h5A5A;
        applyStimulus(16'h0000, 16'h0300, 16'd5);
        fill = 1'b0;
        monitor(9);
        checkOutput("fill_busy_cycles", 32'(busyCycles), 32'd5);
        checkOutput("fill_done_cycle", 32'(doneCycle), 32'd6);
        checkOutput("fill_count", 32'(count), 32'd5);
        checkOutput("fill_ram0", 32'(ram[16'h0300]), 32'h5A5A);
        checkOutput("fill_ram4", 32'(ram[16'h0304]), 32'h5A5A);
        checkOutput("fill_ram5_untouched", 32'(ram[16'h0305]), 32'hDEAD);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
